// File: rtl/mem_access_unit.sv
// Memory stage: drives loads/stores onto a req/ack data bus, steers byte lanes,
// formats load data and stalls the pipeline while a transaction is outstanding.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [31:0] MEM_ALU_result,
  input  logic [31:0] MEM_write_data,
  input  logic [1:0]  MEM_size,
  input  logic        MEM_sign_ext,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] read_data,
  output logic        mem_stall,
  output logic        mem_misaligned,
  output logic        bus_error
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rd_q, rd_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Load shape captured at request time so formatting ignores later inputs.
  logic [1:0]        ld_size_q, ld_size_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic              ld_sext_q, ld_sext_d;

  logic        access, misaligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;

  assign access     = MEM_MemRead | MEM_MemWrite;
  assign misaligned = ((MEM_size == 2'b01) & MEM_ALU_result[0]) |
                      (MEM_size[1] & (|MEM_ALU_result[1:0]));

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = MEM_write_data;
    case (MEM_size)
      2'b00: begin
        be_new    = 4'b0001 << MEM_ALU_result[1:0];
        wdata_new = {4{MEM_write_data[7:0]}};
      end
      2'b01: begin
        be_new    = MEM_ALU_result[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{MEM_write_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (ld_off_q)
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = ld_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_size_q)
      2'b00:   load_fmt = {{24{ld_sext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_fmt = {{16{ld_sext_q & half_sel[15]}}, half_sel};
      default: load_fmt = mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rd_d      = rd_q;
    mis_d     = 1'b0;
    berr_d    = 1'b0;
    cnt_d     = cnt_q;
    ld_size_d = ld_size_q;
    ld_off_d  = ld_off_q;
    ld_sext_d = ld_sext_q;
    unique case (state_q)
      StIdle: begin
        if (access && misaligned) begin
          mis_d = 1'b1;
          rd_d  = '0;
        end else if (access) begin
          state_d   = StReq;
          req_d     = 1'b1;
          we_d      = MEM_MemWrite;
          addr_d    = {MEM_ALU_result[31:2], 2'b00};
          wdata_d   = wdata_new;
          be_d      = be_new;
          cnt_d     = '0;
          ld_size_d = MEM_size;
          ld_off_d  = MEM_ALU_result[1:0];
          ld_sext_d = MEM_sign_ext;
        end
      end
      StReq: begin
        // Ack wins over a timeout that expires in the same cycle.
        if (mem_ack) begin
          state_d = StDone;
          req_d   = 1'b0;
          if (!we_q) rd_d = load_fmt;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1))) begin
          state_d = StDone;
          req_d   = 1'b0;
          berr_d  = 1'b1;
          rd_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rd_q      <= '0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
      cnt_q     <= '0;
      ld_size_q <= '0;
      ld_off_q  <= '0;
      ld_sext_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rd_q      <= rd_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
      cnt_q     <= cnt_d;
      ld_size_q <= ld_size_d;
      ld_off_q  <= ld_off_d;
      ld_sext_q <= ld_sext_d;
    end
  end

  assign mem_req        = req_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_be         = be_q;
  assign read_data      = rd_q;
  assign mem_misaligned = mis_q;
  assign bus_error      = berr_q;
  assign mem_stall      = ((state_q == StIdle) & access & ~misaligned) | (state_q == StReq);

endmodule
